miss_handler: RTL



---
 rtl/cache_pkg.sv | 21 ++
 rtl/victim_select.sv | 23 ++
 rtl/miss_handler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default widths for the cache miss path
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_FILL
    } state_t;

    localparam int DEF_N_WAYS     = 2;
    localparam int DEF_N_POW      = 4;
    localparam int DEF_TAG_BITS   = 21;
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_LINE_BITS  = 128;

    localparam int ADDR_BITS = DEF_TAG_BITS + DEF_INDEX_BITS;
    localparam int WAY_W     = DEF_N_POW;

endpackage

// File: rtl/victim_select.sv
// rtl/victim_select.sv - stateless replacement-way choice: lowest empty way, else round-robin
module victim_select #(
    parameter int N_WAYS = 2,
    parameter int N_POW  = 4
) (
    input  logic [N_WAYS-1:0] line_empty,
    input  logic [N_POW-1:0]  rr,
    output logic [N_POW-1:0]  victim,
    output logic              advance
);

    // Scan downwards so the lowest-numbered empty way wins.
    always_comb begin
        victim  = rr;
        advance = ~|line_empty;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (line_empty[i]) begin
                victim = N_POW'(i);
            end
        end
    end

endmodule

// File: rtl/miss_handler.sv
// rtl/miss_handler.sv - single-outstanding lookup and line-refill controller
module miss_handler
    import cache_pkg::*;
#(
    parameter int N_WAYS     = DEF_N_WAYS,
    parameter int N_POW      = DEF_N_POW,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LINE_BITS  = DEF_LINE_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [TAG_BITS-1:0]            req_tag,
    input  logic [INDEX_BITS-1:0]          req_index,
    output logic [TAG_BITS-1:0]            lk_tag,
    output logic [INDEX_BITS-1:0]          lk_index,
    input  logic                           hit,
    input  logic                           miss,
    input  logic [N_POW-1:0]               hit_way,
    input  logic [N_WAYS-1:0]              line_empty,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [TAG_BITS+INDEX_BITS-1:0] mem_req_addr,
    input  logic                           mem_resp_valid,
    input  logic [LINE_BITS-1:0]           mem_resp_data,
    output logic                           fill_valid,
    output logic [N_POW-1:0]               fill_way,
    output logic [INDEX_BITS-1:0]          fill_index,
    output logic [TAG_BITS-1:0]            fill_tag,
    output logic [LINE_BITS-1:0]           fill_data,
    output logic                           resp_valid,
    output logic                           resp_hit,
    output logic [N_POW-1:0]               resp_way
);

    localparam int N_SETS = 2 ** INDEX_BITS;

    state_t state, state_nx;

    logic [TAG_BITS-1:0]   lk_tag_q;
    logic [INDEX_BITS-1:0] lk_index_q;
    logic [N_POW-1:0]      victim_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [N_POW-1:0]      rr [N_SETS];

    logic [N_POW-1:0] rr_cur;
    logic [N_POW-1:0] rr_next;
    logic [N_POW-1:0] vs_victim;
    logic             vs_advance;

    assign rr_cur  = rr[lk_index_q];
    assign rr_next = (rr_cur == N_POW'(N_WAYS - 1)) ? '0 : rr_cur + 1'b1;

    victim_select #(
        .N_WAYS (N_WAYS),
        .N_POW  (N_POW)
    ) u_victim_select (
        .line_empty (line_empty),
        .rr         (rr_cur),
        .victim     (vs_victim),
        .advance    (vs_advance)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A lookup with neither hit nor miss waits in LOOKUP for the hit check.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (req_valid) state_nx = ST_LOOKUP;
            ST_LOOKUP:   if (hit) state_nx = ST_IDLE;
                         else if (miss) state_nx = ST_MEM_REQ;
            ST_MEM_REQ:  if (mem_req_ready) state_nx = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_resp_valid) state_nx = ST_FILL;
            ST_FILL:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_tag_q   <= '0;
            lk_index_q <= '0;
            victim_q   <= '0;
            line_q     <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                rr[s] <= '0;
            end
        end else begin
            if (state == ST_IDLE && req_valid) begin
                lk_tag_q   <= req_tag;
                lk_index_q <= req_index;
            end
            if (state == ST_LOOKUP && !hit && miss) begin
                victim_q <= vs_victim;
                if (vs_advance) begin
                    rr[lk_index_q] <= rr_next;
                end
            end
            if (state == ST_MEM_WAIT && mem_resp_valid) begin
                line_q <= mem_resp_data;
            end
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        fill_valid    = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_way      = '0;
        case (state)
            ST_IDLE:    req_ready = 1'b1;
            ST_LOOKUP:  if (hit) begin
                            resp_valid = 1'b1;
                            resp_hit   = 1'b1;
                            resp_way   = hit_way;
                        end
            ST_MEM_REQ: mem_req_valid = 1'b1;
            ST_FILL:    begin
                            fill_valid = 1'b1;
                            resp_valid = 1'b1;
                            resp_way   = victim_q;
                        end
            default:    ;
        endcase
    end

    assign lk_tag       = lk_tag_q;
    assign lk_index     = lk_index_q;
    assign mem_req_addr = {lk_tag_q, lk_index_q};
    assign fill_way     = victim_q;
    assign fill_index   = lk_index_q;
    assign fill_tag     = lk_tag_q;
    assign fill_data    = line_q;

endmodule
